vga_pattern_module: RTL and testbench

- Pixel-colour stage directly downstream of the 800x600@60 VGA sync generator, in the vga_clk domain (40 MHz).
- Consumes the generator's Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_Sig and VSYNC_Sig.
- Produces RGB565 pixel data plus sync outputs delayed to match the colour pipeline, so the pins see aligned timing.
- Test patterns: colour bars, checkerboard, bouncing box, or auto-cycle through all three.

---
 rtl/vga_pattern_module.sv | 256 +++++++++++++++++++++++++
 tb/tb_vga_pattern_module.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_module.sv
// ============================================================================
//  Module      : vga_pattern_module
//  Description : RGB565 test-pattern stage for the 800x600 VGA timing chain.
//                Two-stage pipeline with syncs delayed to match.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pattern_module #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 600,
    parameter int BOX_SIZE        = 64,
    parameter int BOX_STEP        = 4,
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        Ready_Sig,
    input  logic [10:0] Column_Addr_Sig,
    input  logic [10:0] Row_Addr_Sig,
    input  logic        HSYNC_Sig,
    input  logic        VSYNC_Sig,
    input  logic [1:0]  Mode_Sel,
    output logic [4:0]  Red_Sig,
    output logic [5:0]  Green_Sig,
    output logic [4:0]  Blue_Sig,
    output logic        HSYNC_Out,
    output logic        VSYNC_Out,
    output logic        Frame_Start
);

    localparam int CNT_W = (FRAMES_PER_MODE > 2) ? $clog2(FRAMES_PER_MODE) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FRAMES_PER_MODE - 1);
    localparam logic [11:0]      c_x_max    = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0]      c_y_max    = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0]      c_step     = 12'(BOX_STEP);
    localparam logic [11:0]      c_box      = 12'(BOX_SIZE);

    localparam logic [15:0] c_white   = 16'hFFFF;
    localparam logic [15:0] c_yellow  = 16'hFFE0;
    localparam logic [15:0] c_cyan    = 16'h07FF;
    localparam logic [15:0] c_green   = 16'h07E0;
    localparam logic [15:0] c_magenta = 16'hF81F;
    localparam logic [15:0] c_red     = 16'hF800;
    localparam logic [15:0] c_blue    = 16'h001F;
    localparam logic [15:0] c_black   = 16'h0000;

    typedef enum logic [1:0] {
        ST_BARS  = 2'd0,
        ST_CHECK = 2'd1,
        ST_BOX   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic [1:0]         r_pattern, w_pattern_nxt;
    logic [1:0]         r_mode_prev;

    logic [10:0]        r_box_x, r_box_y, w_box_x_nxt, w_box_y_nxt;
    logic               r_dir_left, r_dir_up, w_dir_left_nxt, w_dir_up_nxt;

    logic [10:0]        r_col1, r_row1;
    logic               r_ready1, r_hs1, r_vs1;
    logic [15:0]        r_rgb2;
    logic               r_hs2, r_vs2, r_frame_start;

    logic               w_frame_start;
    logic [11:0]        w_bx, w_by, w_col, w_row;
    logic [2:0]         w_bar_idx;
    logic [15:0]        w_bar_rgb, w_chk_rgb, w_box_rgb, w_rgb;

    assign w_frame_start = Ready_Sig && (Column_Addr_Sig == 11'd0) && (Row_Addr_Sig == 11'd0);

    // Pattern selection and auto-cycle sequencing, evaluated only at frame start
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_state     <= ST_BARS;
            r_frame_cnt <= '0;
            r_pattern   <= 2'd0;
            r_mode_prev <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_pattern   <= w_pattern_nxt;
            if (w_frame_start) begin
                r_mode_prev <= Mode_Sel;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_pattern_nxt   = r_pattern;
        if (w_frame_start) begin
            if (Mode_Sel == 2'd3) begin
                if (r_mode_prev != 2'd3) begin
                    w_state_nxt     = ST_BARS;
                    w_frame_cnt_nxt = '0;
                end else if (r_frame_cnt == c_cnt_last) begin
                    w_frame_cnt_nxt = '0;
                    case (r_state)
                        ST_BARS:  w_state_nxt = ST_CHECK;
                        ST_CHECK: w_state_nxt = ST_BOX;
                        default:  w_state_nxt = ST_BARS;
                    endcase
                end else begin
                    w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                end
                w_pattern_nxt = w_state_nxt;
            end else begin
                w_pattern_nxt = Mode_Sel;
            end
        end
    end

    // Box motion: 12-bit compares so position arithmetic never wraps
    assign w_bx = {1'b0, r_box_x};
    assign w_by = {1'b0, r_box_y};

    always_comb begin
        w_box_x_nxt    = r_box_x;
        w_dir_left_nxt = r_dir_left;
        if (!r_dir_left) begin
            if (w_bx + c_step >= c_x_max) begin
                w_box_x_nxt    = c_x_max[10:0];
                w_dir_left_nxt = 1'b1;
            end else begin
                w_box_x_nxt = r_box_x + c_step[10:0];
            end
        end else begin
            if (w_bx <= c_step) begin
                w_box_x_nxt    = 11'd0;
                w_dir_left_nxt = 1'b0;
            end else begin
                w_box_x_nxt = r_box_x - c_step[10:0];
            end
        end
    end

    always_comb begin
        w_box_y_nxt  = r_box_y;
        w_dir_up_nxt = r_dir_up;
        if (!r_dir_up) begin
            if (w_by + c_step >= c_y_max) begin
                w_box_y_nxt  = c_y_max[10:0];
                w_dir_up_nxt = 1'b1;
            end else begin
                w_box_y_nxt = r_box_y + c_step[10:0];
            end
        end else begin
            if (w_by <= c_step) begin
                w_box_y_nxt  = 11'd0;
                w_dir_up_nxt = 1'b0;
            end else begin
                w_box_y_nxt = r_box_y - c_step[10:0];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_box_x    <= 11'd0;
            r_box_y    <= 11'd0;
            r_dir_left <= 1'b0;
            r_dir_up   <= 1'b0;
        end else if (w_frame_start) begin
            r_box_x    <= w_box_x_nxt;
            r_box_y    <= w_box_y_nxt;
            r_dir_left <= w_dir_left_nxt;
            r_dir_up   <= w_dir_up_nxt;
        end
    end

    // Stage 1: capture addresses and syncs
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_col1        <= 11'd0;
            r_row1        <= 11'd0;
            r_ready1      <= 1'b0;
            r_hs1         <= 1'b0;
            r_vs1         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_col1        <= Column_Addr_Sig;
            r_row1        <= Row_Addr_Sig;
            r_ready1      <= Ready_Sig;
            r_hs1         <= HSYNC_Sig;
            r_vs1         <= VSYNC_Sig;
            r_frame_start <= w_frame_start;
        end
    end

    // Bar index = column/100 via compare chain
    always_comb begin
        if      (r_col1 < 11'd100) w_bar_idx = 3'd0;
        else if (r_col1 < 11'd200) w_bar_idx = 3'd1;
        else if (r_col1 < 11'd300) w_bar_idx = 3'd2;
        else if (r_col1 < 11'd400) w_bar_idx = 3'd3;
        else if (r_col1 < 11'd500) w_bar_idx = 3'd4;
        else if (r_col1 < 11'd600) w_bar_idx = 3'd5;
        else if (r_col1 < 11'd700) w_bar_idx = 3'd6;
        else                       w_bar_idx = 3'd7;
    end

    always_comb begin
        case (w_bar_idx)
            3'd0:    w_bar_rgb = c_white;
            3'd1:    w_bar_rgb = c_yellow;
            3'd2:    w_bar_rgb = c_cyan;
            3'd3:    w_bar_rgb = c_green;
            3'd4:    w_bar_rgb = c_magenta;
            3'd5:    w_bar_rgb = c_red;
            3'd6:    w_bar_rgb = c_blue;
            default: w_bar_rgb = c_black;
        endcase
    end

    assign w_col     = {1'b0, r_col1};
    assign w_row     = {1'b0, r_row1};
    assign w_chk_rgb = (r_col1[5] ^ r_row1[5]) ? c_black : c_white;
    assign w_box_rgb = ((w_col >= w_bx) && (w_col < w_bx + c_box) &&
                        (w_row >= w_by) && (w_row < w_by + c_box)) ? c_white : c_blue;

    always_comb begin
        case (r_pattern)
            2'd0:    w_rgb = w_bar_rgb;
            2'd1:    w_rgb = w_chk_rgb;
            default: w_rgb = w_box_rgb;
        endcase
    end

    // Stage 2: blank outside the visible area
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_rgb2 <= 16'd0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
        end else begin
            r_rgb2 <= r_ready1 ? w_rgb : 16'd0;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
        end
    end

    assign Red_Sig     = r_rgb2[15:11];
    assign Green_Sig   = r_rgb2[10:5];
    assign Blue_Sig    = r_rgb2[4:0];
    assign HSYNC_Out   = r_hs2;
    assign VSYNC_Out   = r_vs2;
    assign Frame_Start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_module.sv
// ============================================================================
//  Module      : tb_vga_pattern_module
//  Description : Directed self-checking bench for vga_pattern_module.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_pattern_module;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        Ready_Sig;
    logic [10:0] Column_Addr_Sig;
    logic [10:0] Row_Addr_Sig;
    logic        HSYNC_Sig;
    logic        VSYNC_Sig;
    logic [1:0]  Mode_Sel;
    logic [4:0]  Red_Sig;
    logic [5:0]  Green_Sig;
    logic [4:0]  Blue_Sig;
    logic        HSYNC_Out;
    logic        VSYNC_Out;
    logic        Frame_Start;
    logic [15:0] rgb;

    int tests = 0;
    int fails = 0;
    int bx, by;
    bit mv_left, mv_up;

    vga_pattern_module #(
        .H_ACTIVE        (800),
        .V_ACTIVE        (600),
        .BOX_SIZE        (64),
        .BOX_STEP        (4),
        .FRAMES_PER_MODE (2)
    ) dut (
        .vga_clk         (vga_clk),
        .rst             (rst),
        .Ready_Sig       (Ready_Sig),
        .Column_Addr_Sig (Column_Addr_Sig),
        .Row_Addr_Sig    (Row_Addr_Sig),
        .HSYNC_Sig       (HSYNC_Sig),
        .VSYNC_Sig       (VSYNC_Sig),
        .Mode_Sel        (Mode_Sel),
        .Red_Sig         (Red_Sig),
        .Green_Sig       (Green_Sig),
        .Blue_Sig        (Blue_Sig),
        .HSYNC_Out       (HSYNC_Out),
        .VSYNC_Out       (VSYNC_Out),
        .Frame_Start     (Frame_Start)
    );

    assign rgb = {Red_Sig, Green_Sig, Blue_Sig};

    always #5 vga_clk = ~vga_clk;

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Ready_Sig       = 1'b0;
        Column_Addr_Sig = 11'd1;
        Row_Addr_Sig    = 11'd1;
    endtask

    task automatic model_reset();
        bx = 0; by = 0; mv_left = 1'b0; mv_up = 1'b0;
    endtask

    task automatic model_move();
        if (!mv_left) begin
            if (bx + 4 >= 736) begin bx = 736; mv_left = 1'b1; end
            else bx = bx + 4;
        end else begin
            if (bx <= 4) begin bx = 0; mv_left = 1'b0; end
            else bx = bx - 4;
        end
        if (!mv_up) begin
            if (by + 4 >= 536) begin by = 536; mv_up = 1'b1; end
            else by = by + 4;
        end else begin
            if (by <= 4) begin by = 0; mv_up = 1'b0; end
            else by = by - 4;
        end
    endtask

    function automatic logic [15:0] exp_color(input int pat, input int c, input int r);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        if (pat == 0) return bars[c / 100];
        if (pat == 1) return ((((c / 32) + (r / 32)) % 2) == 0) ? 16'hFFFF : 16'h0000;
        return (c >= bx && c < bx + 64 && r >= by && r < by + 64) ? 16'hFFFF : 16'h001F;
    endfunction

    // Drive one pixel for one cycle, then read its colour two edges later
    task automatic pix(input int c, input int r, input logic rdy, input logic [15:0] exp,
                       input string tag);
        Ready_Sig       = rdy;
        Column_Addr_Sig = 11'(c);
        Row_Addr_Sig    = 11'(r);
        step();
        idle();
        step();
        chk(tag, rgb, exp);
    endtask

    task automatic do_frame(input logic [1:0] mode, input int pat);
        Mode_Sel        = mode;
        Ready_Sig       = 1'b1;
        Column_Addr_Sig = 11'd0;
        Row_Addr_Sig    = 11'd0;
        step();
        model_move();
        chk("frame_start_pulse", {15'd0, Frame_Start}, 16'd1);
        idle();
        step();
        chk("frame_start_single", {15'd0, Frame_Start}, 16'd0);
        chk("frame_origin_rgb", rgb, exp_color(pat, 0, 0));
    endtask

    initial begin
        logic [1:0] m3_modes [12];
        int         m3_pats  [12];
        m3_modes = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3};
        m3_pats  = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 0, 0, 1};

        rst = 1'b1; Ready_Sig = 1'b1; Column_Addr_Sig = 11'd5; Row_Addr_Sig = 11'd5;
        HSYNC_Sig = 1'b0; VSYNC_Sig = 1'b0; Mode_Sel = 2'd0;
        model_reset();
        repeat (10) step();
        chk("reset_rgb", rgb, 16'h0000);
        chk("reset_hsync", {15'd0, HSYNC_Out}, 16'd0);
        chk("reset_frame_start", {15'd0, Frame_Start}, 16'd0);

        rst = 1'b0;
        step();
        chk("latency_1cyc", rgb, 16'h0000);
        step();
        chk("latency_2cyc", rgb, 16'hFFFF);

        // Sync delay
        idle();
        step(); step();
        HSYNC_Sig = 1'b1; VSYNC_Sig = 1'b1;
        step();
        chk("hsync_rise_1cyc", {15'd0, HSYNC_Out}, 16'd0);
        chk("vsync_rise_1cyc", {15'd0, VSYNC_Out}, 16'd0);
        step();
        chk("hsync_rise_2cyc", {15'd0, HSYNC_Out}, 16'd1);
        chk("vsync_rise_2cyc", {15'd0, VSYNC_Out}, 16'd1);
        HSYNC_Sig = 1'b0;
        step();
        chk("hsync_fall_1cyc", {15'd0, HSYNC_Out}, 16'd1);
        step();
        chk("hsync_fall_2cyc", {15'd0, HSYNC_Out}, 16'd0);
        chk("vsync_held", {15'd0, VSYNC_Out}, 16'd1);
        VSYNC_Sig = 1'b0;
        step(); step();
        chk("vsync_fall_2cyc", {15'd0, VSYNC_Out}, 16'd0);

        // Colour bars, no frame start needed after reset
        pix(0,   10, 1'b1, 16'hFFFF, "bar_c0");
        pix(99,  10, 1'b1, 16'hFFFF, "bar_c99");
        pix(100, 10, 1'b1, 16'hFFE0, "bar_c100");
        pix(150, 10, 1'b1, 16'hFFE0, "bar_c150");
        pix(250, 10, 1'b1, 16'h07FF, "bar_c250");
        pix(399, 10, 1'b1, 16'h07E0, "bar_c399");
        pix(400, 10, 1'b1, 16'hF81F, "bar_c400");
        pix(599, 10, 1'b1, 16'hF800, "bar_c599");
        pix(600, 10, 1'b1, 16'h001F, "bar_c600");
        pix(799, 10, 1'b1, 16'h0000, "bar_c799");
        pix(150, 10, 1'b0, 16'h0000, "bar_blank");

        // Checkerboard
        do_frame(2'd1, 1);
        pix(32, 0,  1'b1, 16'h0000, "chk_32_0");
        pix(32, 32, 1'b1, 16'hFFFF, "chk_32_32");
        pix(31, 0,  1'b1, 16'hFFFF, "chk_31_0");
        pix(64, 32, 1'b1, 16'h0000, "chk_64_32");

        // Reset mid-frame; a frame-start coinciding with reset is ignored
        Mode_Sel = 2'd0; Ready_Sig = 1'b1; Column_Addr_Sig = 11'd5; Row_Addr_Sig = 11'd5;
        step(); step();
        chk("prereset_rgb", rgb, 16'hFFFF);
        rst = 1'b1;
        step();
        chk("midreset_rgb", rgb, 16'h0000);
        Column_Addr_Sig = 11'd0; Row_Addr_Sig = 11'd0;
        step();
        chk("reset_wins_fs", {15'd0, Frame_Start}, 16'd0);
        Column_Addr_Sig = 11'd5; Row_Addr_Sig = 11'd5;
        step();
        model_reset();
        rst = 1'b0;
        step();
        chk("resume_1cyc", rgb, 16'h0000);
        step();
        chk("resume_2cyc", rgb, 16'hFFFF);
        idle();
        step();

        // Bouncing box: x walks to 736 then turns back
        for (int k = 1; k <= 200; k++) begin
            do_frame(2'd2, 2);
            if (!(bx == 0 && by == 0)) pix(bx, by, 1'b1, 16'hFFFF, "box_corner");
            if (bx > 0)       pix(bx - 1, by, 1'b1, 16'h001F, "box_left_out");
            if (by > 0)       pix(bx, by - 1, 1'b1, 16'h001F, "box_top_out");
            pix(bx + 63, by + 63, 1'b1, 16'hFFFF, "box_far_corner");
            if (bx + 64 < 800) pix(bx + 64, by, 1'b1, 16'h001F, "box_right_out");
        end

        // Auto-cycle, including restart on re-entry
        for (int i = 0; i < 12; i++) begin
            do_frame(m3_modes[i], m3_pats[i]);
            pix(150, 300, 1'b1, exp_color(m3_pats[i], 150, 300), "auto_pattern");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
